// File: rtl/mire_pkg.sv
`default_nettype none
// ============================================================================
// Module : mire_pkg
// Brief  : Shared types, constants and helpers for the mire pattern master.
// Rev    : 1.0  initial release
// ============================================================================
package mire_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        PAUSE = 2'd2
    } state_t;

    localparam logic [31:0] WHITE = 32'h00FF_FFFF;

    // Counter width for values 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mire_pix_cnt.sv
`default_nettype none
// ============================================================================
// Module : mire_pix_cnt
// Brief  : Raster position (x, y, frame) and byte address, stepped by advance.
// Rev    : 1.0  initial release
// ============================================================================
module mire_pix_cnt
    import mire_pkg::*;
#(
    parameter int HDISP = 800,
    parameter int VDISP = 480,
    localparam int XW   = cnt_width(HDISP),
    localparam int YW   = cnt_width(VDISP)
) (
    input  logic          sys_clk,
    input  logic          sys_rst,
    input  logic          advance,
    output logic [XW-1:0] x_nxt,
    output logic [YW-1:0] y_nxt,
    output logic [7:0]    frame_nxt,
    output logic [31:0]   adr,
    output logic          end_of_line,
    output logic          end_of_frame
);

    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic [7:0]    frame_q, frame_d;
    logic [31:0]   adr_q, adr_d;

    assign end_of_line  = (x_q == XW'(HDISP - 1));
    assign end_of_frame = end_of_line && (y_q == YW'(VDISP - 1));

    // Address tracks the raster incrementally so no multiplier is needed.
    always_comb begin
        x_d     = x_q;
        y_d     = y_q;
        frame_d = frame_q;
        adr_d   = adr_q;
        if (advance) begin
            if (end_of_frame) begin
                x_d     = '0;
                y_d     = '0;
                frame_d = frame_q + 8'd1;
                adr_d   = '0;
            end else if (end_of_line) begin
                x_d   = '0;
                y_d   = y_q + YW'(1);
                adr_d = adr_q + 32'd4;
            end else begin
                x_d   = x_q + XW'(1);
                adr_d = adr_q + 32'd4;
            end
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            x_q     <= '0;
            y_q     <= '0;
            frame_q <= '0;
            adr_q   <= '0;
        end else begin
            x_q     <= x_d;
            y_q     <= y_d;
            frame_q <= frame_d;
            adr_q   <= adr_d;
        end
    end

    assign x_nxt     = x_d;
    assign y_nxt     = y_d;
    assign frame_nxt = frame_d;
    assign adr       = adr_q;

endmodule
`default_nettype wire

// File: rtl/mire_wshb.sv
`default_nettype none
// ============================================================================
// Module : mire_wshb
// Brief  : Wishbone master writing a grid/gradient test pattern to a framebuffer.
// Rev    : 1.0  initial release
// ============================================================================
module mire_wshb
    import mire_pkg::*;
#(
    parameter int HDISP     = 800,
    parameter int VDISP     = 480,
    parameter int BURST     = 64,
    parameter int PAUSE_CYC = 2,
    parameter int GRID      = 16
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        enable,
    output logic        wshb_cyc,
    output logic        wshb_stb,
    output logic        wshb_we,
    output logic [3:0]  wshb_sel,
    output logic [2:0]  wshb_cti,
    output logic [1:0]  wshb_bte,
    output logic [31:0] wshb_adr,
    output logic [31:0] wshb_dat_ms,
    input  logic        wshb_ack
);

    localparam int XW = cnt_width(HDISP);
    localparam int YW = cnt_width(VDISP);
    localparam int BW = cnt_width(BURST);
    localparam int PW = cnt_width(PAUSE_CYC);

    state_t        state_q, state_d;
    logic          cyc_q, cyc_d;
    logic [BW-1:0] burst_q, burst_d;
    logic [PW-1:0] pause_q, pause_d;
    logic [31:0]   dat_q, dat_d;

    logic          advance;
    logic [XW-1:0] x_nxt;
    logic [YW-1:0] y_nxt;
    logic [7:0]    frame_nxt;
    logic [31:0]   pix_adr;
    logic          end_of_line;
    logic          end_of_frame;
    logic          unused_flags;
    logic          grid_hit;

    assign advance = (state_q == WRITE) && wshb_ack;

    mire_pix_cnt #(
        .HDISP (HDISP),
        .VDISP (VDISP)
    ) u_pix_cnt (
        .sys_clk      (sys_clk),
        .sys_rst      (sys_rst),
        .advance      (advance),
        .x_nxt        (x_nxt),
        .y_nxt        (y_nxt),
        .frame_nxt    (frame_nxt),
        .adr          (pix_adr),
        .end_of_line  (end_of_line),
        .end_of_frame (end_of_frame)
    );

    // Raster flags are informational here; the FSM keys only on ack/burst.
    assign unused_flags = end_of_line ^ end_of_frame;

    // Data is formatted from the position the counter holds after this edge,
    // so the registered word always matches the registered address.
    always_comb begin
        grid_hit = ((x_nxt & XW'(GRID - 1)) == '0) || ((y_nxt & YW'(GRID - 1)) == '0);
        dat_d    = grid_hit ? WHITE : {8'h00, 8'(x_nxt), 8'(y_nxt), frame_nxt};
    end

    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        burst_d = burst_q;
        pause_d = pause_q;
        case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d = WRITE;
                    cyc_d   = 1'b1;
                end
            end
            WRITE: begin
                if (wshb_ack) begin
                    if (burst_q == BW'(BURST - 1)) begin
                        burst_d = '0;
                        pause_d = '0;
                        state_d = PAUSE;
                        cyc_d   = 1'b0;
                    end else begin
                        burst_d = burst_q + BW'(1);
                        if (!enable) begin
                            state_d = IDLE;
                            cyc_d   = 1'b0;
                        end
                    end
                end
            end
            PAUSE: begin
                if (pause_q == PW'(PAUSE_CYC - 1)) begin
                    pause_d = '0;
                    state_d = enable ? WRITE : IDLE;
                    cyc_d   = enable;
                end else begin
                    pause_d = pause_q + PW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cyc_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q <= IDLE;
            cyc_q   <= 1'b0;
            burst_q <= '0;
            pause_q <= '0;
            dat_q   <= '0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            burst_q <= burst_d;
            pause_q <= pause_d;
            dat_q   <= dat_d;
        end
    end

    assign wshb_cyc    = cyc_q;
    assign wshb_stb    = cyc_q;
    assign wshb_we     = 1'b1;
    assign wshb_sel    = 4'hF;
    assign wshb_cti    = 3'b000;
    assign wshb_bte    = 2'b00;
    assign wshb_adr    = pix_adr;
    assign wshb_dat_ms = dat_q;

endmodule
`default_nettype wire

// File: tb/tb_mire_wshb.sv
`default_nettype none
// ============================================================================
// Module : tb_mire_wshb
// Brief  : Self-checking bench for mire_wshb with a pixel scoreboard.
// Rev    : 1.0  initial release
// ============================================================================
module tb_mire_wshb;

    localparam int HDISP     = 8;
    localparam int VDISP     = 4;
    localparam int BURST     = 4;
    localparam int PAUSE_CYC = 2;
    localparam int GRID      = 4;
    localparam logic [31:0] C_WHITE = 32'h00FF_FFFF;

    localparam int ACK_TIED = 0;
    localparam int ACK_WAIT = 1;
    localparam int ACK_HOLD = 2;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic        enable  = 1'b0;
    logic        wshb_ack = 1'b0;
    logic        wshb_cyc, wshb_stb, wshb_we;
    logic [3:0]  wshb_sel;
    logic [2:0]  wshb_cti;
    logic [1:0]  wshb_bte;
    logic [31:0] wshb_adr, wshb_dat_ms;

    mire_wshb #(
        .HDISP     (HDISP),
        .VDISP     (VDISP),
        .BURST     (BURST),
        .PAUSE_CYC (PAUSE_CYC),
        .GRID      (GRID)
    ) dut (
        .sys_clk     (sys_clk),
        .sys_rst     (sys_rst),
        .enable      (enable),
        .wshb_cyc    (wshb_cyc),
        .wshb_stb    (wshb_stb),
        .wshb_we     (wshb_we),
        .wshb_sel    (wshb_sel),
        .wshb_cti    (wshb_cti),
        .wshb_bte    (wshb_bte),
        .wshb_adr    (wshb_adr),
        .wshb_dat_ms (wshb_dat_ms),
        .wshb_ack    (wshb_ack)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct packed {
        logic [31:0] adr;
        logic [31:0] dat;
    } xfer_t;

    xfer_t       sb[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          mx = 0, my = 0;
    logic [7:0]  mf = 8'd0;
    int          ack_mode = ACK_TIED;
    int          ack_wcnt = 0;
    int          total_acks = 0;

    // monitor state
    logic        cyc_prev = 1'b0;
    logic        prev_wait = 1'b0;
    logic        gap_valid = 1'b0;
    logic        ended_full = 1'b0;
    logic        en_low = 1'b0;
    int          gap = 0;
    int          tenure_acks = 0;
    logic [31:0] held_adr = '0, held_dat = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic xfer_t model_pixel(input int x, input int y, input logic [7:0] f);
        xfer_t t;
        t.adr = 32'((y * HDISP + x) * 4);
        if ((x % GRID == 0) || (y % GRID == 0)) t.dat = C_WHITE;
        else                                     t.dat = {8'h00, 8'(x), 8'(y), f};
        return t;
    endfunction

    task automatic push_expected();
        sb.push_back(model_pixel(mx, my, mf));
        mx++;
        if (mx == HDISP) begin
            mx = 0;
            my++;
            if (my == VDISP) begin
                my = 0;
                mf = mf + 8'd1;
            end
        end
    endtask

    task automatic model_reset();
        mx = 0;
        my = 0;
        mf = 8'd0;
        sb.delete();
    endtask

    // Ack driver: expected pixel is queued whenever an ack is offered to a live strobe.
    initial begin
        forever begin
            @(posedge sys_clk);
            #1;
            if (sys_rst) begin
                wshb_ack = (ack_mode == ACK_TIED);
                ack_wcnt = 0;
            end else begin
                case (ack_mode)
                    ACK_TIED: begin
                        wshb_ack = 1'b1;
                        ack_wcnt = 0;
                        if (wshb_stb) push_expected();
                    end
                    ACK_WAIT: begin
                        if (!wshb_stb || wshb_ack) begin
                            wshb_ack = 1'b0;
                            ack_wcnt = wshb_stb ? 1 : 0;
                        end else if (ack_wcnt >= 3) begin
                            wshb_ack = 1'b1;
                            push_expected();
                        end else begin
                            ack_wcnt++;
                        end
                    end
                    default: begin
                        wshb_ack = 1'b0;
                        ack_wcnt = 0;
                    end
                endcase
            end
        end
    end

    // Monitor: scoreboard pop, wait-state stability, burst/pause shape.
    initial begin
        xfer_t e;
        forever begin
            @(negedge sys_clk);
            if (sys_rst) begin
                cyc_prev    = 1'b0;
                prev_wait   = 1'b0;
                gap_valid   = 1'b0;
                tenure_acks = 0;
            end else begin
                if (wshb_stb && prev_wait) begin
                    check("wait_adr", wshb_adr, held_adr);
                    check("wait_dat", wshb_dat_ms, held_dat);
                end
                if (wshb_stb && !wshb_ack && !prev_wait) begin
                    held_adr = wshb_adr;
                    held_dat = wshb_dat_ms;
                end
                prev_wait = wshb_stb && !wshb_ack;

                if (wshb_cyc && wshb_stb && wshb_ack) begin
                    total_acks++;
                    if (sb.size() == 0) begin
                        check("sb_depth", 32'(sb.size()), 32'd1);
                    end else begin
                        e = sb.pop_front();
                        check("xfer_adr", wshb_adr, e.adr);
                        check("xfer_dat", wshb_dat_ms, e.dat);
                    end
                end

                if (wshb_cyc) begin
                    if (!cyc_prev) begin
                        if (gap_valid && ended_full && !en_low) begin
                            check("pause_len", 32'(gap), 32'(PAUSE_CYC));
                            check("burst_align", {28'd0, wshb_adr[3:0]}, 32'd0);
                        end
                        tenure_acks = 0;
                    end
                    if (wshb_stb && wshb_ack) begin
                        tenure_acks++;
                        if (tenure_acks > BURST) check("burst_len", 32'(tenure_acks), 32'(BURST));
                    end
                end else begin
                    if (cyc_prev) begin
                        ended_full = (tenure_acks == BURST);
                        gap        = 0;
                        en_low     = 1'b0;
                        gap_valid  = 1'b1;
                    end
                    gap++;
                    if (!enable) en_low = 1'b1;
                end
                cyc_prev = wshb_cyc;
            end
        end
    end

    task automatic wait_adr(input logic [31:0] target);
        for (int i = 0; i < 400; i++) begin
            @(negedge sys_clk);
            if (wshb_cyc && wshb_stb && wshb_adr == target) break;
        end
        check("found_adr", wshb_adr, target);
    endtask

    task automatic release_and_check_start(input string tag);
        @(posedge sys_clk);
        #1 sys_rst = 1'b0;
        @(negedge sys_clk);
        check({tag, "_idle_cyc"}, 32'(wshb_cyc), 32'd0);
        @(negedge sys_clk);
        check({tag, "_cyc"}, 32'(wshb_cyc), 32'd1);
        check({tag, "_adr"}, wshb_adr, 32'd0);
        check({tag, "_dat"}, wshb_dat_ms, C_WHITE);
    endtask

    initial begin
        logic [31:0] a_hold;
        enable   = 1'b1;
        ack_mode = ACK_TIED;
        sys_rst  = 1'b1;
        repeat (3) @(negedge sys_clk);
        check("rst_cyc", 32'(wshb_cyc), 32'd0);
        check("rst_stb", 32'(wshb_stb), 32'd0);
        check("rst_adr", wshb_adr, 32'd0);
        check("rst_dat", wshb_dat_ms, 32'd0);
        check("const_bus", {21'd0, wshb_we, wshb_sel, wshb_cti, wshb_bte}, {21'd0, 1'b1, 4'hF, 3'b000, 2'b00});

        release_and_check_start("start");

        // pixel (1,1) of frame 0
        wait_adr(32'h24);
        check("pix11_f0", wshb_dat_ms, 32'h0001_0100);

        // run past the frame wrap, then pixel (1,1) of frame 1
        for (int i = 0; i < 400 && total_acks < 34; i++) @(negedge sys_clk);
        check("wrap_reached", 32'(total_acks >= 34), 32'd1);
        wait_adr(32'h24);
        check("pix11_f1", wshb_dat_ms, 32'h0001_0101);

        // wait states
        ack_mode = ACK_WAIT;
        repeat (80) @(negedge sys_clk);

        // async reset in the middle of a held transfer
        for (int i = 0; i < 20; i++) begin
            if (wshb_stb && !wshb_ack) break;
            @(negedge sys_clk);
        end
        sys_rst = 1'b1;
        #1;
        check("async_rst_cyc", 32'(wshb_cyc), 32'd0);
        check("async_rst_stb", 32'(wshb_stb), 32'd0);
        model_reset();
        ack_mode = ACK_TIED;
        repeat (2) @(negedge sys_clk);
        release_and_check_start("restart");
        wait_adr(32'h24);
        check("pix11_after_rst", wshb_dat_ms, 32'h0001_0100);

        // enable dropped while the slave holds off ack
        for (int i = 0; i < 100; i++) begin
            @(negedge sys_clk);
            if (wshb_cyc && wshb_stb && wshb_adr[3:0] == 4'h4) break;
        end
        check("drop_setup", {28'd0, wshb_adr[3:0]}, 32'h4);
        a_hold   = wshb_adr + 32'd4;
        ack_mode = ACK_HOLD;
        @(negedge sys_clk);
        enable = 1'b0;
        repeat (3) begin
            @(negedge sys_clk);
            check("hold_stb", 32'(wshb_stb), 32'd1);
            check("hold_adr", wshb_adr, a_hold);
        end
        ack_mode = ACK_TIED;
        @(negedge sys_clk);
        check("drop_ack_stb", 32'(wshb_stb), 32'd1);
        repeat (3) begin
            @(negedge sys_clk);
            check("drop_idle_cyc", 32'(wshb_cyc), 32'd0);
        end
        enable = 1'b1;
        @(negedge sys_clk);
        check("resume_cyc", 32'(wshb_cyc), 32'd1);
        check("resume_adr", wshb_adr, a_hold + 32'd4);

        repeat (60) @(negedge sys_clk);
        enable = 1'b0;
        repeat (12) @(negedge sys_clk);
        check("sb_left", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
